// File: rtl/data_mem_responder.sv
// Purpose: word-organised data memory answering one load/store request at a time.
// Latency: response valid WAIT_CYCLES+1 edges after (and counting) the accept edge.
// Backpressure: the response is held until rsp_ready; req_ready stays low until then.
//
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready          request handshake; req_ready comes from the state register only
//   req_we, req_addr, req_wdata, req_be
//                                store flag, word-aligned byte address, store data, byte enables
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata, rsp_err           load data (0 for stores/faults), access fault flag
module data_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state, state_n;
    logic [3:0] wait_cnt, wait_cnt_n;

    // Request captured at accept time
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_be;

    logic [31:0] mem [DEPTH_WORDS];

    logic              accept;
    logic              enter_resp;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_err;
    logic [IDX_W-1:0]  acc_idx;
    logic              mem_we;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && (state == ST_IDLE) && rst_n;

    // With zero wait states the access happens on the accept edge itself, so the
    // live request fields are used; otherwise the captured copy is used.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_be    = lat_be;
        if (state == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
    end

    assign acc_err = (acc_addr[1:0] != 2'b00) ||
                     ({2'b00, acc_addr[ADDR_W-1:2]} >= DEPTH_LIMIT);
    assign acc_idx = acc_addr[IDX_W+1:2];

    // Next state and counter
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_n    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_n    = ST_WAIT;
                        wait_cnt_n = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_n    = ST_RESP;
                    enter_resp = rst_n;
                end else begin
                    wait_cnt_n = wait_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // rst_n gates the write so an edge arriving while reset is held never commits a store.
    assign mem_we = enter_resp && acc_we && !acc_err && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
        end
    end

    // Response registers: loaded on the edge entering RESP, cleared after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (!acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
        end else if ((state == ST_RESP) && rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose: randomized self-checking bench for data_mem_responder, two instances (2 and 0 wait states).
// Latency: responses expected WAIT_CYCLES+1 edges after the accept edge (accept edge counted).
// Backpressure: rsp_ready held low for random stretches while stability is checked.
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    data_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    int errors = 0;
    int checks = 0;

    // Reference memory image per instance
    logic [31:0] model_mem [2][DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    endfunction

    // One full transaction; hold = cycles with rsp_ready low after rsp_valid,
    // poke = present a competing store to word 0 while the response is held.
    task automatic txn(input int d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input int hold, input bit poke);
        logic [31:0] exp_rd;
        logic [31:0] word;
        bit          exp_err;
        int          edges;
        exp_err = is_err(addr);
        exp_rd  = 32'd0;
        if (!exp_err) begin
            word = model_mem[d][addr >> 2];
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
                model_mem[d][addr >> 2] = word;
            end else begin
                exp_rd = word;
            end
        end
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        edges = 1;
        while (!rsp_valid[d] && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", 32'(edges), 32'(wait_of(d) + 1));
        check("rsp_err", 32'(rsp_err[d]), 32'(exp_err));
        check("rsp_rdata", rsp_rdata[d], exp_rd);
        for (int c = 0; c < hold; c++) begin
            if (poke) begin
                req_valid[d] = 1'b1;
                req_we[d]    = 1'b1;
                req_addr[d]  = 32'd0;
                req_wdata[d] = 32'hBAD0_BAD0;
                req_be[d]    = 4'hF;
            end
            @(posedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid[d]), 32'd1);
            check("hold_rdata", rsp_rdata[d], exp_rd);
            check("hold_err", 32'(rsp_err[d]), 32'(exp_err));
            check("hold_req_ready", 32'(req_ready[d]), 32'd0);
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        check("post_hs_valid", 32'(rsp_valid[d]), 32'd0);
        check("post_hs_req_ready", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int          d;
        int          r;
        logic [31:0] addr;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
            req_be[i]    = 4'd0;
            rsp_ready[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            check("reset_req_ready", 32'(req_ready[i]), 32'd1);
            check("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check("reset_rsp_err", 32'(rsp_err[i]), 32'd0);
            check("reset_rsp_rdata", rsp_rdata[i], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Give every word a known value
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < DEPTH; w++)
                txn(i, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, 1'b0);

        // Store/load and byte enables
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0);
        txn(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 0, 1'b0);
        check("t3_word", model_mem[0][4], 32'hDE22_BE44);
        txn(0, 1'b1, 32'h14, 32'h5555_AAAA, 4'h0, 0, 1'b0);
        txn(0, 1'b0, 32'h14, 32'd0, 4'h0, 0, 1'b0);

        // Faults
        txn(0, 1'b0, 32'h402, 32'd0, 4'hF, 0, 1'b0);
        txn(0, 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
        txn(0, 1'b0, 32'h0, 32'd0, 4'hF, 0, 1'b0);
        txn(0, 1'b1, 32'h3FC, 32'h0BAD_F00D, 4'hF, 0, 1'b0);
        txn(0, 1'b0, 32'h3FC, 32'd0, 4'hF, 0, 1'b0);

        // Backpressure with a competing request that must be ignored
        txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 5, 1'b1);
        txn(0, 1'b0, 32'h0, 32'd0, 4'hF, 0, 1'b0);
        txn(1, 1'b0, 32'h18, 32'd0, 4'hF, 5, 1'b1);
        txn(1, 1'b0, 32'h0, 32'd0, 4'hF, 0, 1'b0);

        // Reset during WAIT drops the store
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'hCAFE_F00D;
        req_be[0]    = 4'hF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check("t6_in_wait_ready", 32'(req_ready[0]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_req_ready", 32'(req_ready[0]), 32'd1);
        check("mid_reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("mid_reset_rsp_err", 32'(rsp_err[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        txn(0, 1'b0, 32'h20, 32'd0, 4'hF, 0, 1'b0);

        // Zero wait states
        txn(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
        txn(1, 1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0);
        txn(1, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, 1'b0);
        txn(1, 1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 7)       addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (r == 7) addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 8) addr = 32'($urandom_range(DEPTH, 1023)) << 2;
            else             addr = $urandom | 32'h8000_0000;
            txn(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
